// File: rtl/peripheral_pkg.sv
// Shared constants and helpers for the memory-mapped peripheral block.
// Register offsets, TCON bit positions and the I/O window base.
package peripheral_pkg;

    localparam logic [31:0] IO_BASE = 32'h4000_0000;

    localparam logic [4:0] OFF_TH   = 5'h00;
    localparam logic [4:0] OFF_TL   = 5'h04;
    localparam logic [4:0] OFF_TCON = 5'h08;
    localparam logic [4:0] OFF_LED  = 5'h0C;
    localparam logic [4:0] OFF_SW   = 5'h10;
    localparam logic [4:0] OFF_DIGI = 5'h14;

    localparam int TCON_EN = 0;
    localparam int TCON_IE = 1;
    localparam int TCON_IS = 2;

    typedef enum logic [2:0] {
        SEL_TH,
        SEL_TL,
        SEL_TCON,
        SEL_LED,
        SEL_SW,
        SEL_DIGI,
        SEL_NONE
    } sel_e;

    // Map a word index inside the window to a register select.
    function automatic sel_e decode_off(input logic [2:0] word);
        sel_e s;
        case ({word, 2'b00})
            OFF_TH:   s = SEL_TH;
            OFF_TL:   s = SEL_TL;
            OFF_TCON: s = SEL_TCON;
            OFF_LED:  s = SEL_LED;
            OFF_SW:   s = SEL_SW;
            OFF_DIGI: s = SEL_DIGI;
            default:  s = SEL_NONE;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/peripheral_bus_reload_timer.sv
// Reload timer: TH reload value, TL counter, TCON control/status.
// Overflow reloads TL from TH and latches the interrupt status bit.
import peripheral_pkg::*;

module reload_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_th_i,
    input  logic        wr_tl_i,
    input  logic        wr_tcon_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] th_o,
    output logic [31:0] tl_o,
    output logic [2:0]  tcon_o,
    output logic        irq_o
);

    logic [31:0] th_q, th_d;
    logic [31:0] tl_q, tl_d;
    logic [2:0]  tcon_q, tcon_d;
    logic        ovf;

    // Count/reload, with bus writes taking priority over timer activity.
    always_comb begin
        ovf    = tcon_q[TCON_EN] && (tl_q == 32'hFFFF_FFFF);
        th_d   = wr_th_i ? wdata_i : th_q;
        tl_d   = tl_q;
        if (tcon_q[TCON_EN]) begin
            tl_d = ovf ? th_q : tl_q + 32'd1;
        end
        if (wr_tl_i) begin
            tl_d = wdata_i;
        end
        tcon_d = tcon_q;
        tcon_d[TCON_IS] = tcon_q[TCON_IS] | (ovf & tcon_q[TCON_IE]);
        if (wr_tcon_i) begin
            tcon_d[TCON_IE:TCON_EN] = wdata_i[TCON_IE:TCON_EN];
            // An overflow coincident with an ISR clear must not be lost.
            tcon_d[TCON_IS] = wdata_i[TCON_IS]
                            | (ovf & wdata_i[TCON_IE]);
        end
    end

    // Timer state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            th_q   <= '0;
            tl_q   <= '0;
            tcon_q <= '0;
        end else begin
            th_q   <= th_d;
            tl_q   <= tl_d;
            tcon_q <= tcon_d;
        end
    end

    assign th_o   = th_q;
    assign tl_o   = tl_q;
    assign tcon_o = tcon_q;
    assign irq_o  = tcon_q[TCON_IS];

endmodule

// File: rtl/peripheral_bus.sv
// I/O window responder: decode, read mux, LED and digit registers.
// The reload timer lives in its own sub-module.
import peripheral_pkg::*;

module peripheral_bus #(
    parameter logic [31:0] BASE_ADDR = IO_BASE,
    parameter int          LED_W     = 8,
    parameter int          SW_W      = 8,
    parameter int          DIGI_W    = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [31:0]       Address,
    input  logic [31:0]       WriteData,
    output logic [31:0]       ReadData,
    input  logic [SW_W-1:0]   Switch,
    output logic [LED_W-1:0]  LED,
    output logic [DIGI_W-1:0] Digi,
    output logic              IRQ
);

    sel_e              sel;
    logic              in_win;
    logic [LED_W-1:0]  led_q, led_d;
    logic [DIGI_W-1:0] digi_q, digi_d;
    logic [31:0]       th, tl;
    logic [2:0]        tcon;
    logic              unused_addr;

    // Byte lanes are not used; accesses are word-wide.
    assign unused_addr = ^Address[1:0];

    assign in_win = (Address[31:5] == BASE_ADDR[31:5]);
    assign sel    = in_win ? decode_off(Address[4:2]) : SEL_NONE;

    reload_timer u_timer (
        .clk       (clk),
        .reset     (reset),
        .wr_th_i   (MemWrite && sel == SEL_TH),
        .wr_tl_i   (MemWrite && sel == SEL_TL),
        .wr_tcon_i (MemWrite && sel == SEL_TCON),
        .wdata_i   (WriteData),
        .th_o      (th),
        .tl_o      (tl),
        .tcon_o    (tcon),
        .irq_o     (IRQ)
    );

    // Next-state for the display registers.
    always_comb begin
        led_d  = led_q;
        digi_d = digi_q;
        if (MemWrite && sel == SEL_LED) begin
            led_d = WriteData[LED_W-1:0];
        end
        if (MemWrite && sel == SEL_DIGI) begin
            digi_d = WriteData[DIGI_W-1:0];
        end
    end

    // Display registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            led_q  <= '0;
            digi_q <= '0;
        end else begin
            led_q  <= led_d;
            digi_q <= digi_d;
        end
    end

    // Zero-latency read mux; everything zero-extended.
    always_comb begin
        ReadData = '0;
        if (MemRead) begin
            case (sel)
                SEL_TH:   ReadData = th;
                SEL_TL:   ReadData = tl;
                SEL_TCON: ReadData[2:0] = tcon;
                SEL_LED:  ReadData[LED_W-1:0] = led_q;
                SEL_SW:   ReadData[SW_W-1:0] = Switch;
                SEL_DIGI: ReadData[DIGI_W-1:0] = digi_q;
                default:  ReadData = '0;
            endcase
        end
    end

    assign LED  = led_q;
    assign Digi = digi_q;

endmodule

// File: tb/tb_peripheral_bus.sv
// Self-checking bench for peripheral_bus: vector table, timer
// sequences and a randomized run against a register-map model.
module tb_peripheral_bus;

    localparam logic [31:0] BASE = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite;
    logic [31:0] Address, WriteData, ReadData;
    logic [7:0]  Switch;
    logic [7:0]  LED;
    logic [11:0] Digi;
    logic        IRQ;

    int checks = 0;
    int errors = 0;

    logic [31:0] rd_seen, rd_exp;

    logic [31:0] m_th, m_tl;
    logic [2:0]  m_tcon;
    logic [7:0]  m_led;
    logic [11:0] m_digi;

    always #5 clk = ~clk;

    peripheral_bus dut (
        .clk       (clk),
        .reset     (reset),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .Address   (Address),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .Switch    (Switch),
        .LED       (LED),
        .Digi      (Digi),
        .IRQ       (IRQ)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic int word_of(input logic [31:0] a);
        if ((a & 32'hFFFF_FFE0) != BASE) return -1;
        return int'((a - BASE) >> 2);
    endfunction

    function automatic logic [31:0] m_read(input logic rd,
                                           input logic [31:0] a,
                                           input logic [7:0] sw);
        if (!rd) return 32'h0;
        case (word_of(a))
            0: return m_th;
            1: return m_tl;
            2: return {29'h0, m_tcon};
            3: return {24'h0, m_led};
            4: return {24'h0, sw};
            5: return {20'h0, m_digi};
            default: return 32'h0;
        endcase
    endfunction

    task automatic m_step(input logic rst, input logic wr,
                          input logic [31:0] a, input logic [31:0] d);
        logic        ev;
        logic [31:0] n_th, n_tl;
        logic [2:0]  n_tcon;
        if (!rst) begin
            m_th = 0; m_tl = 0; m_tcon = 0; m_led = 0; m_digi = 0;
            return;
        end
        ev     = m_tcon[0] && (m_tl == 32'hFFFF_FFFF);
        n_th   = m_th;
        n_tl   = m_tcon[0] ? (ev ? m_th : m_tl + 1) : m_tl;
        n_tcon = {m_tcon[2] | (ev & m_tcon[1]), m_tcon[1:0]};
        if (wr) begin
            case (word_of(a))
                0: n_th = d;
                1: n_tl = d;
                2: n_tcon = {d[2] | (ev & d[1]), d[1:0]};
                3: m_led = d[7:0];
                5: m_digi = d[11:0];
                default: ;
            endcase
        end
        m_th = n_th; m_tl = n_tl; m_tcon = n_tcon;
    endtask

    task automatic tick(input logic rst, input logic rd,
                        input logic wr, input logic [31:0] a,
                        input logic [31:0] d);
        reset = rst; MemRead = rd; MemWrite = wr;
        Address = a; WriteData = d;
        @(negedge clk);
        rd_seen = ReadData;
        rd_exp  = m_read(rd, a, Switch);
        @(posedge clk);
        m_step(rst, wr, a, d);
        #1;
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [7:0]  sw;
        logic [31:0] exp_rd;
        logic [7:0]  exp_led;
        logic [11:0] exp_digi;
    } vec_t;

    vec_t vt[14];
    int   n;

    initial begin
        m_th = 0; m_tl = 0; m_tcon = 0; m_led = 0; m_digi = 0;
        Switch = 8'h00;

        vt[0]  = '{0, 1, 32'h4000_0014, 32'h140, 8'h00, 32'h0, 8'h00, 12'h140};
        vt[1]  = '{1, 0, 32'h4000_0014, 32'h0, 8'h00, 32'h140, 8'h00, 12'h140};
        vt[2]  = '{0, 1, 32'h4000_000C, 32'h1234, 8'h00, 32'h0, 8'h34, 12'h140};
        vt[3]  = '{1, 0, 32'h4000_000C, 32'h0, 8'h00, 32'h34, 8'h34, 12'h140};
        vt[4]  = '{1, 0, 32'h4000_0010, 32'h0, 8'hA5, 32'hA5, 8'h34, 12'h140};
        vt[5]  = '{0, 1, 32'h4000_0010, 32'hDEADBEEF, 8'hA5, 32'h0, 8'h34, 12'h140};
        vt[6]  = '{0, 1, 32'h4000_0018, 32'hDEADBEEF, 8'hA5, 32'h0, 8'h34, 12'h140};
        vt[7]  = '{0, 1, 32'h0000_0004, 32'hDEADBEEF, 8'hA5, 32'h0, 8'h34, 12'h140};
        vt[8]  = '{1, 0, 32'h4000_0018, 32'h0, 8'hA5, 32'h0, 8'h34, 12'h140};
        vt[9]  = '{1, 0, 32'h0000_0010, 32'h0, 8'hA5, 32'h0, 8'h34, 12'h140};
        vt[10] = '{1, 0, 32'h4000_0004, 32'h0, 8'hA5, 32'h0, 8'h34, 12'h140};
        vt[11] = '{0, 0, 32'h4000_000C, 32'h0, 8'hA5, 32'h0, 8'h34, 12'h140};
        vt[12] = '{1, 1, 32'h4000_000C, 32'h56, 8'h3C, 32'h34, 8'h56, 12'h140};
        vt[13] = '{1, 0, 32'h4000_000F, 32'h0, 8'h3C, 32'h56, 8'h56, 12'h140};

        // Reset overrides a simultaneous LED write.
        tick(0, 0, 1, 32'h4000_000C, 32'hFF);
        tick(0, 0, 1, 32'h4000_000C, 32'hFF);
        chk("rst_led", {24'h0, LED}, 32'h0);
        chk("rst_digi", {20'h0, Digi}, 32'h0);
        chk("rst_irq", {31'h0, IRQ}, 32'h0);
        tick(1, 1, 0, 32'h4000_0008, 32'h0);
        chk("rst_tcon_rd", rd_seen, 32'h0);

        foreach (vt[i]) begin
            Switch = vt[i].sw;
            tick(1, vt[i].rd, vt[i].wr, vt[i].addr, vt[i].wd);
            chk($sformatf("vec%0d_rd", i), rd_seen, vt[i].exp_rd);
            chk($sformatf("vec%0d_led", i), {24'h0, LED},
                {24'h0, vt[i].exp_led});
            chk($sformatf("vec%0d_digi", i), {20'h0, Digi},
                {20'h0, vt[i].exp_digi});
        end

        // Reload period.
        tick(1, 0, 1, BASE + 32'h0, 32'hFFFF_3CAF);
        tick(1, 0, 1, BASE + 32'h4, 32'hFFFF_3CAF);
        tick(1, 0, 1, BASE + 32'h8, 32'h3);
        n = 0;
        while (!IRQ && n < 60000) begin
            tick(1, 0, 0, 32'h0, 32'h0);
            n++;
        end
        chk("period", n, 50001);
        tick(1, 1, 0, BASE + 32'h4, 32'h0);
        chk("reload_tl", rd_seen, 32'hFFFF_3CAF);
        tick(1, 0, 1, BASE + 32'h8, 32'h0);
        chk("clear_irq", {31'h0, IRQ}, 32'h0);

        // Coincident clear: period-2 timer, rewrite TCON=3 at overflow.
        tick(1, 0, 1, BASE + 32'h0, 32'hFFFF_FFFE);
        tick(1, 0, 1, BASE + 32'h4, 32'hFFFF_FFFE);
        tick(1, 0, 1, BASE + 32'h8, 32'h3);
        tick(1, 0, 0, 32'h0, 32'h0);
        tick(1, 0, 0, 32'h0, 32'h0);
        chk("coin_irq_up", {31'h0, IRQ}, 32'h1);
        tick(1, 0, 0, 32'h0, 32'h0);
        tick(1, 0, 1, BASE + 32'h8, 32'h3);
        chk("coin_irq_kept", {31'h0, IRQ}, 32'h1);
        tick(1, 1, 0, BASE + 32'h8, 32'h0);
        chk("coin_tcon_rd", rd_seen, 32'h7);
        tick(1, 0, 1, BASE + 32'h8, 32'h0);
        chk("coin_ie_off", {31'h0, IRQ}, 32'h0);

        // Write vs count.
        tick(1, 0, 1, BASE + 32'h8, 32'h1);
        tick(1, 0, 1, BASE + 32'h4, 32'h10);
        tick(1, 1, 1, BASE + 32'h4, 32'h5);
        chk("wvc_old", rd_seen, 32'h10);
        tick(1, 1, 0, BASE + 32'h4, 32'h0);
        chk("wvc_tl5", rd_seen, 32'h5);
        tick(1, 1, 0, BASE + 32'h4, 32'h0);
        chk("wvc_tl6", rd_seen, 32'h6);
        tick(1, 0, 1, BASE + 32'h8, 32'h0);

        // Randomized traffic against the model.
        for (int k = 0; k < 2000; k++) begin
            logic        r_rst, r_rd, r_wr;
            logic [31:0] a, d;
            int          kind;
            r_rst = ($urandom_range(0, 63) != 0);
            r_rd  = 1'($urandom_range(0, 1));
            r_wr  = ($urandom_range(0, 2) == 0);
            kind  = $urandom_range(0, 9);
            if (kind == 0) a = $urandom;
            else if (kind == 1) a = BASE + 32'h20 + ($urandom_range(0, 7) << 2);
            else a = BASE | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) d = 32'hFFFF_FFFF - $urandom_range(0, 8);
            else d = $urandom;
            Switch = 8'($urandom);
            tick(r_rst, r_rd, r_wr, a, d);
            chk("rnd_rd", rd_seen, rd_exp);
            chk("rnd_led", {24'h0, LED}, {24'h0, m_led});
            chk("rnd_digi", {20'h0, Digi}, {20'h0, m_digi});
            chk("rnd_irq", {31'h0, IRQ}, {31'h0, m_tcon[2]});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/peripheral_bus.md
# peripheral_bus

- Memory-mapped peripheral responder at the CPU's data-memory port, decoding the `0x4000_0000` I/O window.
- Accepts the loads and stores the CPU program issues to a reload timer (TH/TL/TCON), an LED register, a switch input port and a 7-segment digit register.
- Raises a level interrupt to the CPU on timer overflow.
- Sits beside data memory; the CPU's address decoder routes accesses with `Address[31:28] == 4'h4` here.

## Interface
- `BASE_ADDR`, default `32'h4000_0000`: base of the register window.
- `LED_W`, default 8: LED register width.
- `SW_W`, default 8: switch input width.
- `DIGI_W`, default 12: digit register width; bits [11:8] are one-hot anodes, bits [6:0] are active-low segments.
- `clk` input, 1 bit: system clock.
- `reset` input, 1 bit: synchronous, active-low reset.
- `MemRead` input, 1 bit: read strobe.
- `MemWrite` input, 1 bit: write strobe.
- `Address` input, 32 bits: byte address; bits [1:0] are ignored.
- `WriteData` input, 32 bits: store data.
- `ReadData` output, 32 bits: load data, combinational.
- `Switch` input, `SW_W` bits: board switches.
- `LED` output, `LED_W` bits: LED register.
- `Digi` output, `DIGI_W` bits: digit register.
- `IRQ` output, 1 bit: timer interrupt, equal to TCON[2].

## Operation
- Register map (offset from `BASE_ADDR`):
  - 0x00 TH: 32-bit, R/W.
  - 0x04 TL: 32-bit, R/W.
  - 0x08 TCON: bits [2:0], R/W. Bit 0 = enable, bit 1 = interrupt enable, bit 2 = interrupt status.
  - 0x0C LED: R/W, zero-extended on read.
  - 0x10 Switch: read-only, zero-extended; writes are ignored.
  - 0x14 Digi: R/W, zero-extended on read.
- Unmapped offsets, or any address outside the window: reads return 0 and writes are ignored.
- Reads:
  - `ReadData` = selected register when `MemRead` = 1; otherwise 0.
  - TCON reads as {29'b0, TCON[2:0]}.
- Timer, on each cycle with TCON[0] = 1:
  - If TL == 32'hFFFF_FFFF: TL ← TH (overflow event).
  - Otherwise: TL ← TL + 1, wrapping modulo 2^32.
- Overflow event with TCON[1] = 1 sets TCON[2]. TCON[2] stays set until software writes it to 0.
- With TCON[0] = 0, TL holds.
- Write priorities in the same cycle as timer activity:
  - A write to TL overrides both the increment and the reload.
  - A write to TH takes effect for the next reload only. A reload in the same cycle uses the old TH.
  - A write to TCON loads bits [1:0] from `WriteData`. Bit 2 becomes `WriteData[2]` OR (overflow event AND new TCON[1]), so an interrupt coincident with an ISR clear is not lost.
- Reset applies at a clock edge with `reset` = 0:
  - TH, TL, TCON, LED and Digi all go to 0, so `IRQ` = 0.
  - Reset overrides any simultaneous write.
  - Asserting reset mid-count abandons the count; there is no pending state.

## Timing
- Writes: registered at the `clk` edge where `MemWrite` = 1; visible on outputs and reads the next cycle.
- Reads: zero-latency combinational path from `Address`, `MemRead` and register state.
  - A read of TL returns the pre-edge value.
  - A read and write to the same register in one cycle returns the old value.
- Overflow period = (32'hFFFF_FFFF − TH) + 1 enabled cycles.
- `IRQ` rises one cycle after the edge at which TL == 32'hFFFF_FFFF is sampled with TCON[1:0] = 2'b11.
- `IRQ` falls one cycle after the clearing write.
- `Switch` is sampled combinationally and not synchronized here. The board top synchronizes it.

## Structure
- Shared package `peripheral_pkg` holds:
  - Register offset constants: `OFF_TH`, `OFF_TL`, `OFF_TCON`, `OFF_LED`, `OFF_SW`, `OFF_DIGI`.
  - TCON bit indices: `TCON_EN`, `TCON_IE`, `TCON_IS`.
  - The I/O window base.
- One sub-module is natural: `reload_timer`, which holds TH/TL/TCON, counts, reloads and sets status.
- `peripheral_bus` keeps address decode, the read mux, LED and Digi.

## Test plan
- Reset: hold `reset` = 0 for 2 cycles with `MemWrite` = 1 to LED, data 0xFF → LED, Digi, TCON and `IRQ` all 0. Read of 0x40000008 returns 0.
- Reload period: write TH = 0xFFFF3CAF, TL = 0xFFFF3CAF, TCON = 3.
  - `IRQ` rises after exactly 50001 enabled cycles, and TL reads 0xFFFF3CAF.
  - Writing TCON = 0 drops `IRQ` the next cycle.
- Coincident clear: write TCON = 3 at the edge where TL == 0xFFFFFFFF → TCON[2] remains 1 and `IRQ` stays high.
- Write vs. count: TCON = 1, TL = 0x10, then write TL = 0x5 the next cycle → TL reads 0x5, then 0x6, with no increment lost or duplicated.
- Display path:
  - Write 0x14 = 0x140 → `Digi` = 12'h140 and a readback returns 0x00000140.
  - Write 0x0C = 0x1234 → `LED` = 8'h34.
  - `Switch` = 8'hA5 → read of 0x10 returns 0xA5.
- Unmapped: write 0xDEADBEEF to 0x40000018 and to 0x00000004 → no register changes; both reads return 0.
